// File: rtl/alu_mult_sequencer.sv
// Sequential 16x16 -> 32 multiplier that borrows the EX-stage ALU adder for
// one shift-add step per cycle; the result lands in the HI/LO registers.
module alu_mult_sequencer #(
    parameter logic [2:0] OP_ADD  = 3'b010,
    parameter logic [2:0] OP_IDLE = 3'b000,
    parameter int         WIDTH   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] alu_x,
    output logic [WIDTH-1:0] alu_y,
    output logic             alu_cin,
    output logic [2:0]       alu_opcod,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_cout
);

    localparam int                   CW     = $clog2(WIDTH);
    localparam logic [CW-1:0]        LAST   = CW'(WIDTH - 1);
    localparam logic [CW-1:0]        CNT1   = CW'(1);
    localparam logic [WIDTH-1:0]     ONE_W  = WIDTH'(1);
    localparam logic [2*WIDTH-1:0]   ONE_P  = (2*WIDTH)'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ITER,
        S_FIX,
        S_DONE
    } state_t;

    state_t             state_q;
    logic [WIDTH-1:0]   mcand_q;
    logic [WIDTH-1:0]   mplier_q;
    logic [WIDTH-1:0]   acc_q;
    logic               sm_q;
    logic               neg_q;
    logic [CW-1:0]      cnt_q;
    logic               busy_q;
    logic               done_q;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;

    logic [WIDTH-1:0]   mcand_abs_d;
    logic [WIDTH-1:0]   mplier_abs_d;
    logic [2*WIDTH-1:0] prod_d;

    // Magnitudes for LOAD, sign fix-up for FIX, and ALU ownership decode.
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned, which would infer a latch.
    always_comb begin
        mcand_abs_d  = mcand_q;
        mplier_abs_d = mplier_q;
        if (sm_q && mcand_q[WIDTH-1])  mcand_abs_d  = ~mcand_q + ONE_W;
        if (sm_q && mplier_q[WIDTH-1]) mplier_abs_d = ~mplier_q + ONE_W;

        prod_d = {acc_q, mplier_q};
        if (neg_q) prod_d = ~{acc_q, mplier_q} + ONE_P;

        alu_x     = '0;
        alu_y     = '0;
        alu_cin   = 1'b0;
        alu_opcod = OP_IDLE;
        if (state_q == S_ITER) begin
            alu_x     = acc_q;
            alu_y     = mcand_q;
            alu_opcod = OP_ADD;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: all state is plain flops, so everything is cleared on reset; there is no memory to leave untouched.
            state_q  <= S_IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            sm_q     <= 1'b0;
            neg_q    <= 1'b0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        mcand_q  <= op_a;
                        mplier_q <= op_b;
                        sm_q     <= signed_mode;
                        busy_q   <= 1'b1;
                        state_q  <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    mcand_q  <= mcand_abs_d;
                    mplier_q <= mplier_abs_d;
                    neg_q    <= sm_q & (mcand_q[WIDTH-1] ^ mplier_q[WIDTH-1]);
                    acc_q    <= '0;
                    cnt_q    <= '0;
                    state_q  <= S_ITER;
                end
                S_ITER: begin
                    // Right shift of {carry, partial sum, multiplier} by one bit.
                    if (mplier_q[0]) begin
                        acc_q    <= {alu_cout, alu_out[WIDTH-1:1]};
                        mplier_q <= {alu_out[0], mplier_q[WIDTH-1:1]};
                    end else begin
                        acc_q    <= {1'b0, acc_q[WIDTH-1:1]};
                        mplier_q <= {acc_q[0], mplier_q[WIDTH-1:1]};
                    end
                    cnt_q <= cnt_q + CNT1;
                    if (cnt_q == LAST) state_q <= S_FIX;
                end
                S_FIX: begin
                    {hi_q, lo_q} <= prod_d;
                    busy_q       <= 1'b0;
                    done_q       <= 1'b1;
                    state_q      <= S_DONE;
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_alu_mult_sequencer.sv
// Self-checking bench: behavioural timing/arithmetic model compared every
// cycle, plus directed literal products and latency checks.
module tb_alu_mult_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        signed_mode;
    logic [15:0] op_a;
    logic [15:0] op_b;
    logic        busy;
    logic        done;
    logic [15:0] hi;
    logic [15:0] lo;
    logic [15:0] alu_x;
    logic [15:0] alu_y;
    logic        alu_cin;
    logic [2:0]  alu_opcod;
    logic [15:0] alu_out;
    logic        alu_cout;

    int errors = 0;
    int checks = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    alu_mult_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .signed_mode(signed_mode),
        .op_a       (op_a),
        .op_b       (op_b),
        .busy       (busy),
        .done       (done),
        .hi         (hi),
        .lo         (lo),
        .alu_x      (alu_x),
        .alu_y      (alu_y),
        .alu_cin    (alu_cin),
        .alu_opcod  (alu_opcod),
        .alu_out    (alu_out),
        .alu_cout   (alu_cout)
    );

    // ALU stand-in: adds only when asked to, otherwise produces something unhelpful.
    assign {alu_cout, alu_out} = (alu_opcod == 3'b010) ?
        ({1'b0, alu_x} + {1'b0, alu_y} + {16'h0000, alu_cin}) :
        {1'b0, alu_x ^ alu_y};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: t counts cycles since acceptance (1 = LOAD, 2..17 = ITER, 18 = FIX, 19 = DONE).
    int          t = 0;
    logic [15:0] m_a, m_b;
    bit          m_sm;
    logic [31:0] m_prod = 32'h0;

    function automatic logic [15:0] mag(input logic [15:0] v, input bit sm);
        if (sm && v[15]) return 16'(-int'($signed(v)));
        return v;
    endfunction

    function automatic logic [31:0] product(input logic [15:0] a, input logic [15:0] b, input bit sm);
        if (sm) return 32'(longint'($signed(a)) * longint'($signed(b)));
        return 32'(longint'(a) * longint'(b));
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            t      = 0;
            m_prod = 32'h0;
        end else if (t == 0) begin
            if (start) begin
                m_a  = op_a;
                m_b  = op_b;
                m_sm = signed_mode;
                t    = 1;
            end
        end else if (t == 19) begin
            t = 0;
        end else begin
            t = t + 1;
            if (t == 19) m_prod = product(m_a, m_b, m_sm);
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            bit          iter;
            longint      ma, mb, acc;
            int          k;
            iter = (t >= 2) && (t <= 17);
            check("busy", {31'h0, busy}, {31'h0, (t >= 1 && t <= 18)});
            check("done", {31'h0, done}, {31'h0, (t == 19)});
            check("hi_lo", {hi, lo}, m_prod);
            check("alu_opcod", {29'h0, alu_opcod}, iter ? 32'h2 : 32'h0);
            check("alu_cin", {31'h0, alu_cin}, 32'h0);
            if (iter) begin
                k   = t - 2;
                ma  = longint'(mag(m_a, m_sm));
                mb  = longint'(mag(m_b, m_sm));
                acc = (ma * (mb & ((64'sd1 <<< k) - 1))) >>> k;
                check("alu_x", {16'h0, alu_x}, 32'(acc));
                check("alu_y", {16'h0, alu_y}, 32'(ma));
            end else begin
                check("alu_x", {16'h0, alu_x}, 32'h0);
                check("alu_y", {16'h0, alu_y}, 32'h0);
            end
        end
    end

    // Waits for done after the acceptance edge; n is the cycle index of done (start cycle = 0).
    task automatic wait_done(input bit noise, input int hold_from, input logic [15:0] ha,
                             input logic [15:0] hb, input bit hsm,
                             output int n, output int nbusy, output int nadd);
        bit seen = 1'b0;
        nbusy = 0;
        nadd  = 0;
        n     = 0;
        for (int i = 1; i <= 40 && !seen; i++) begin
            @(negedge clk);
            n = i;
            if (busy) nbusy++;
            if (alu_opcod == 3'b010) nadd++;
            if (done) seen = 1'b1;
            if (noise) begin
                op_a        = 16'($urandom);
                op_b        = 16'($urandom);
                signed_mode = 1'($urandom);
                start       = (i < 16) ? 1'($urandom_range(0, 3) == 0) : 1'b0;
            end
            if (i == hold_from) begin
                start       = 1'b1;
                op_a        = ha;
                op_b        = hb;
                signed_mode = hsm;
            end
        end
        if (!seen) check("done_timeout", 32'h0, 32'h1);
    endtask

    task automatic launch(input logic [15:0] a, input logic [15:0] b, input bit sm);
        @(posedge clk);
        #2;
        op_a        = a;
        op_b        = b;
        signed_mode = sm;
        start       = 1'b1;
        @(posedge clk);
        #2;
        start = 1'b0;
    endtask

    task automatic run_lit(input string name, input logic [15:0] a, input logic [15:0] b,
                           input bit sm, input logic [31:0] exp);
        int n, nb, na;
        launch(a, b, sm);
        wait_done(1'b0, 0, 16'h0, 16'h0, 1'b0, n, nb, na);
        check({name, "_latency"}, n, 19);
        check({name, "_busy_cycles"}, nb, 18);
        check({name, "_add_cycles"}, na, 16);
        check({name, "_result"}, {hi, lo}, exp);
    endtask

    initial begin
        int n, nb, na;
        rst_n = 1'b0; start = 1'b0; signed_mode = 1'b0; op_a = '0; op_b = '0;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_busy", {31'h0, busy}, 32'h0);
        check("reset_done", {31'h0, done}, 32'h0);
        check("reset_hilo", {hi, lo}, 32'h0);
        check("reset_opcod", {29'h0, alu_opcod}, 32'h0);
        cmp_en = 1'b1;

        run_lit("u3x5",      16'h0003, 16'h0005, 1'b0, 32'h0000_000F);
        run_lit("umax",      16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE_0001);
        run_lit("sm3x5",     16'hFFFD, 16'h0005, 1'b1, 32'hFFFF_FFF1);
        run_lit("s8000sq",   16'h8000, 16'h8000, 1'b1, 32'h4000_0000);
        run_lit("zero",      16'h0000, 16'h1234, 1'b0, 32'h0000_0000);
        run_lit("u1x8000",   16'h0001, 16'h8000, 1'b0, 32'h0000_8000);

        // Second start raised in ITER cycle 5 and held: accepted only in the IDLE cycle after DONE.
        launch(16'h0007, 16'h0009, 1'b0);
        wait_done(1'b0, 7, 16'h1234, 16'h0002, 1'b0, n, nb, na);
        check("busy_start_first_latency", n, 19);
        check("busy_start_first_result", {hi, lo}, 32'h0000_003F);
        @(posedge clk);
        @(posedge clk);
        #2;
        start = 1'b0;
        wait_done(1'b0, 0, 16'h0, 16'h0, 1'b0, n, nb, na);
        check("busy_start_second_latency", n, 19);
        check("busy_start_second_result", {hi, lo}, 32'h0000_2468);

        // Reset in the middle of ITER abandons the operation.
        launch(16'h0101, 16'h0011, 1'b0);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(negedge clk);
        check("midreset_busy", {31'h0, busy}, 32'h0);
        check("midreset_hilo", {hi, lo}, 32'h0);
        nb = 0;
        repeat (25) begin
            @(negedge clk);
            if (done) nb++;
        end
        check("midreset_no_done", nb, 0);
        run_lit("after_reset", 16'h0101, 16'h0011, 1'b0, 32'h0000_1111);

        // Randomized operations with operand/start noise while busy.
        for (int r = 0; r < 60; r++) begin
            logic [15:0] a, b;
            bit sm;
            a  = 16'($urandom);
            b  = 16'($urandom);
            sm = 1'($urandom);
            if (r % 10 == 0) a = 16'h8000;
            if (r % 10 == 1) b = 16'hFFFF;
            launch(a, b, sm);
            wait_done(1'b1, 0, 16'h0, 16'h0, 1'b0, n, nb, na);
            check("rand_latency", n, 19);
            start = 1'b0;
        end

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
